// File: rtl/vram_dp_clr_if.sv
// Bus bundle for the dual-port video RAM: CPU read/write port, video read port
// and clear-engine control/status.
interface vram_dp_clr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_din;
  logic [DATA_WIDTH-1:0] cpu_dout;
  logic                  vid_re;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic [DATA_WIDTH-1:0] vid_dout;
  logic                  vid_valid;
  logic                  clear_start;
  logic                  clear_busy;
  logic                  clear_done;

  modport master (
    output cpu_we, cpu_addr, cpu_din, vid_re, vid_addr, clear_start,
    input  cpu_dout, vid_dout, vid_valid, clear_busy, clear_done
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_din, vid_re, vid_addr, clear_start,
    output cpu_dout, vid_dout, vid_valid, clear_busy, clear_done
  );
endinterface

// File: rtl/vram_dp_clr.sv
// Dual-port video RAM: CPU read/write port, independent read-only video port,
// and a hardware engine that fills the whole array with CLEAR_VALUE on request.
module vram_dp_clr #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  vram_dp_clr_if.slave      bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLEARING = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r;
  logic [ADDR_WIDTH:0]   cnt_r;
  logic [DATA_WIDTH-1:0] cpu_dout_r;
  logic [DATA_WIDTH-1:0] vid_dout_r;
  logic                  vid_valid_r;
  logic                  clear_busy_r;
  logic                  clear_done_r;

  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  // Single write port arbitration: clear engine owns the array while clearing, CPU otherwise.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = bus.cpu_addr;
    mem_wdata_s = bus.cpu_din;
    if (reset) begin
      mem_we_s = 1'b0;
    end else if (state_r == ST_CLEARING) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cnt_r[ADDR_WIDTH-1:0];
      mem_wdata_s = CLEAR_VALUE;
    end else if ((state_r == ST_IDLE) && bus.cpu_we) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Array storage; deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Clear FSM, read ports and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {(ADDR_WIDTH+1){1'b0}};
      cpu_dout_r   <= {DATA_WIDTH{1'b0}};
      vid_dout_r   <= {DATA_WIDTH{1'b0}};
      vid_valid_r  <= 1'b0;
      clear_busy_r <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      // Video port never stalls; reads see pre-write data on any same-cycle write.
      if (bus.vid_re) begin
        vid_dout_r  <= mem_r[bus.vid_addr];
        vid_valid_r <= 1'b1;
      end else begin
        vid_valid_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          cpu_dout_r   <= mem_r[bus.cpu_addr];
          clear_done_r <= 1'b0;
          if (bus.clear_start) begin
            state_r      <= ST_CLEARING;
            cnt_r        <= {(ADDR_WIDTH+1){1'b0}};
            clear_busy_r <= 1'b1;
          end
        end
        ST_CLEARING: begin
          // Extra counter bit keeps the terminal count from wrapping back to 0.
          cnt_r <= cnt_r + (ADDR_WIDTH+1)'(1);
          if (cnt_r == LAST_ADDR) begin
            state_r      <= ST_DONE;
            clear_done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r      <= ST_IDLE;
          clear_busy_r <= 1'b0;
          clear_done_r <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          clear_busy_r <= 1'b0;
          clear_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_dout   = cpu_dout_r;
  assign bus.vid_dout   = vid_dout_r;
  assign bus.vid_valid  = vid_valid_r;
  assign bus.clear_busy = clear_busy_r;
  assign bus.clear_done = clear_done_r;
endmodule
